// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes, burst FSM
// states and the burstable-mode predicate.
package usr_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'b000,
      SHR  = 3'b001,
      SHL  = 3'b010,
      LOAD = 3'b011,
      ROR  = 3'b100,
      ROL  = 3'b101,
      ASR  = 3'b110,
      CLR  = 3'b111
   } usr_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } usr_state_e;

   // Only the pure shift/rotate operations make sense to repeat in a burst.
   function automatic logic usr_is_shift(usr_mode_e m);
      return (m == SHR) || (m == SHL) || (m == ROR) || (m == ROL) || (m == ASR);
   endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: decides which operation the datapath applies each edge,
// repeating a latched shift/rotate for burst_len steps and pulsing done after.
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [2:0]       op,
   output logic             op_valid,
   output logic             state,
   output logic             done
);

   // op/op_valid: when op_valid is high the datapath applies op at the next
   // rising edge; there is no ready, the datapath always accepts.

   usr_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   usr_mode_e        mode_q, mode_d;
   logic             done_q, done_d;
   usr_mode_e        mode_in;

   assign mode_in = usr_mode_e'(mode);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= HOLD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   // cnt_q holds the number of steps still to run after the start edge, so the
   // BUSY edge that sees cnt_q==1 executes the final step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      op       = HOLD;
      op_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (burst_start && usr_is_shift(mode_in)) begin
               mode_d = mode_in;
               if (burst_len == '0) begin
                  cnt_d  = '0;
                  done_d = 1'b1;
               end else begin
                  op       = mode_in;
                  op_valid = 1'b1;
                  cnt_d    = burst_len - CNT_W'(1);
                  if (burst_len == CNT_W'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = BUSY;
                  end
               end
            end else if (en) begin
               op       = mode_in;
               op_valid = 1'b1;
            end
         end
         BUSY: begin
            op       = mode_q;
            op_valid = 1'b1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;
   assign done  = done_q;

endmodule

// File: rtl/univ_shift_reg_p.sv
// Universal shift register with burst repeat. Define USR_PARITY_EN to add a
// registered parity output tracking ^q.
module univ_shift_reg_p
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,output logic            parity
`endif
);

   logic [2:0]       op;
   logic             op_valid;
   logic             ctrl_state;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_d;

   usr_burst_ctrl #(
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .burst_start (burst_start),
      .burst_len   (burst_len),
      .op          (op),
      .op_valid    (op_valid),
      .state       (ctrl_state),
      .done        (done)
   );

   always_comb begin
      q_next = q;
      unique case (usr_mode_e'(op))
         HOLD:    q_next = q;
         SHR:     q_next = {sin_l, q[WIDTH-1:1]};
         SHL:     q_next = {q[WIDTH-2:0], sin_r};
         LOAD:    q_next = din;
         ROR:     q_next = {q[0], q[WIDTH-1:1]};
         ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         ASR:     q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         CLR:     q_next = '0;
         default: q_next = q;
      endcase
   end

   assign q_d = op_valid ? q_next : q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else begin
         q <= q_d;
      end
   end

`ifdef USR_PARITY_EN
   // Parity is taken from the value being written so it never lags q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         parity <= 1'b0;
      end else begin
         parity <= ^q_d;
      end
   end
`endif

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign busy   = (usr_state_e'(ctrl_state) == BUSY);

endmodule
